// File: rtl/stage_sequencer.sv
// Launch-sequence controller: stage config storage, tick-based burn timer,
// live mass integration, separation strobes and burnout snapshot handshake.
module stage_sequencer #(
  parameter int N_STAGES  = 3,
  parameter int TICK_DIV  = 1000,
  parameter int SEP_TICKS = 2,
  parameter int W         = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         cfg_we,
  input  logic [1:0]   cfg_idx,
  input  logic [W-1:0] cfg_burn_ms,
  input  logic [W-1:0] cfg_mdot,
  input  logic [W-1:0] cfg_mprop,
  input  logic [W-1:0] cfg_mdry,
  input  logic         launch,
  input  logic         abort,
  input  logic         calc_ack,
  output logic         calc_req,
  output logic         thrust_en,
  output logic         sep_pulse,
  output logic [1:0]   stage_idx,
  output logic [W-1:0] mass,
  output logic [W-1:0] burn_ms,
  output logic [2:0]   state,
  output logic         done,
  output logic         aborted
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PREP  = 3'd1,
    BURN  = 3'd2,
    CALC  = 3'd3,
    SEP   = 3'd4,
    COAST = 3'd5,
    DONE  = 3'd6,
    ABORT = 3'd7
  } state_t;

  localparam int TW = $clog2(TICK_DIV);
  localparam int CW = (SEP_TICKS > 1) ? $clog2(SEP_TICKS) : 1;
  localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [CW-1:0] COAST_LAST = CW'(SEP_TICKS - 1);
  localparam logic [1:0]    LAST_STAGE = 2'(N_STAGES - 1);

  // Arrays are sized for the full 2-bit index range; unused slots stay zero.
  logic [W-1:0] burn_cfg_reg  [4];
  logic [W-1:0] mdot_cfg_reg  [4];
  logic [W-1:0] mprop_cfg_reg [4];
  logic [W-1:0] mdry_cfg_reg  [4];

  state_t        state_reg,     state_next;
  logic [TW-1:0] tick_cnt_reg;
  logic [CW-1:0] coast_cnt_reg, coast_cnt_next;
  logic [1:0]    k_reg,         k_next;
  logic [1:0]    stage_idx_reg, stage_idx_next;
  logic [W-1:0]  mass_reg,      mass_next;
  logic [W-1:0]  burn_ms_reg,   burn_ms_next;
  logic [W-1:0]  rem_prop_reg,  rem_prop_next;

  logic         tick;
  logic         abort_hit;
  logic [1:0]   stage_inc;
  logic [W-1:0] burn_sub;
  logic [W-1:0] burn_tgt;
  logic [W-1:0] burn_inc;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_cfg
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          burn_cfg_reg[gi]  <= '0;
          mdot_cfg_reg[gi]  <= '0;
          mprop_cfg_reg[gi] <= '0;
          mdry_cfg_reg[gi]  <= '0;
        end else if (cfg_we && (state_reg == IDLE) && (cfg_idx == 2'(gi)) && (gi < N_STAGES)) begin
          burn_cfg_reg[gi]  <= cfg_burn_ms;
          mdot_cfg_reg[gi]  <= cfg_mdot;
          mprop_cfg_reg[gi] <= cfg_mprop;
          mdry_cfg_reg[gi]  <= cfg_mdry;
        end
      end
    end
  endgenerate

  assign tick      = (tick_cnt_reg == TICK_LAST);
  assign abort_hit = abort && (state_reg inside {PREP, BURN, CALC, SEP, COAST});
  assign stage_inc = stage_idx_reg + 2'd1;
  assign burn_inc  = burn_ms_reg + W'(1);
  assign burn_tgt  = (burn_cfg_reg[stage_idx_reg] == '0) ? W'(1) : burn_cfg_reg[stage_idx_reg];
  // Never consume more than what is left, so mass bottoms out at the dry stack.
  assign burn_sub  = (rem_prop_reg < mdot_cfg_reg[stage_idx_reg]) ? rem_prop_reg
                                                                   : mdot_cfg_reg[stage_idx_reg];

  always_comb begin
    state_next     = state_reg;
    k_next         = k_reg;
    stage_idx_next = stage_idx_reg;
    mass_next      = mass_reg;
    burn_ms_next   = burn_ms_reg;
    rem_prop_next  = rem_prop_reg;
    coast_cnt_next = coast_cnt_reg;
    if (abort_hit) begin
      state_next = ABORT;
    end else begin
      case (state_reg)
        IDLE: if (launch) begin
          mass_next  = '0;
          k_next     = 2'd0;
          state_next = PREP;
        end
        PREP: begin
          mass_next = mass_reg + mprop_cfg_reg[k_reg] + mdry_cfg_reg[k_reg];
          k_next    = k_reg + 2'd1;
          if (k_reg == LAST_STAGE) begin
            stage_idx_next = 2'd0;
            burn_ms_next   = '0;
            rem_prop_next  = mprop_cfg_reg[0];
            state_next     = BURN;
          end
        end
        BURN: if (tick) begin
          burn_ms_next = burn_inc;
          if (burn_inc >= burn_tgt) begin
            // Burnout dumps whatever propellant is still on board.
            mass_next     = mass_reg - rem_prop_reg;
            rem_prop_next = '0;
            state_next    = CALC;
          end else begin
            mass_next     = mass_reg - burn_sub;
            rem_prop_next = rem_prop_reg - burn_sub;
          end
        end
        CALC: if (calc_ack) begin
          state_next = (stage_idx_reg == LAST_STAGE) ? DONE : SEP;
        end
        SEP: begin
          mass_next      = mass_reg - mdry_cfg_reg[stage_idx_reg];
          coast_cnt_next = '0;
          state_next     = COAST;
        end
        COAST: if (tick) begin
          if (coast_cnt_reg == COAST_LAST) begin
            stage_idx_next = stage_inc;
            burn_ms_next   = '0;
            rem_prop_next  = mprop_cfg_reg[stage_inc];
            state_next     = BURN;
          end else begin
            coast_cnt_next = coast_cnt_reg + CW'(1);
          end
        end
        DONE:  if (launch) state_next = IDLE;
        ABORT: if (!abort && launch) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      tick_cnt_reg  <= '0;
      coast_cnt_reg <= '0;
      k_reg         <= '0;
      stage_idx_reg <= '0;
      mass_reg      <= '0;
      burn_ms_reg   <= '0;
      rem_prop_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      coast_cnt_reg <= coast_cnt_next;
      k_reg         <= k_next;
      stage_idx_reg <= stage_idx_next;
      mass_reg      <= mass_next;
      burn_ms_reg   <= burn_ms_next;
      rem_prop_reg  <= rem_prop_next;
      // Tick phase restarts on every state change so each state times from zero.
      if ((state_next != state_reg) || tick) tick_cnt_reg <= '0;
      else                                   tick_cnt_reg <= tick_cnt_reg + TW'(1);
    end
  end

  assign state     = state_reg;
  assign stage_idx = stage_idx_reg;
  assign mass      = mass_reg;
  assign burn_ms   = burn_ms_reg;
  assign thrust_en = (state_reg == BURN);
  assign calc_req  = (state_reg == CALC);
  assign sep_pulse = (state_reg == SEP);
  assign done      = (state_reg == DONE);
  assign aborted   = (state_reg == ABORT);

endmodule

// File: tb/tb_stage_sequencer.sv
// Directed bench for stage_sequencer with TICK_DIV=4, SEP_TICKS=2, 3 stages.
module tb_stage_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cfg_we;
  logic [1:0]  cfg_idx;
  logic [31:0] cfg_burn_ms, cfg_mdot, cfg_mprop, cfg_mdry;
  logic        launch, abort, calc_ack;
  logic        calc_req, thrust_en, sep_pulse, done, aborted;
  logic [1:0]  stage_idx;
  logic [31:0] mass, burn_ms;
  logic [2:0]  state;

  int total = 0;
  int bad   = 0;
  int sep_cnt = 0;

  stage_sequencer #(.N_STAGES(3), .TICK_DIV(4), .SEP_TICKS(2), .W(32)) dut (
    .clk(clk), .reset_n(reset_n), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_burn_ms(cfg_burn_ms), .cfg_mdot(cfg_mdot), .cfg_mprop(cfg_mprop),
    .cfg_mdry(cfg_mdry), .launch(launch), .abort(abort), .calc_ack(calc_ack),
    .calc_req(calc_req), .thrust_en(thrust_en), .sep_pulse(sep_pulse),
    .stage_idx(stage_idx), .mass(mass), .burn_ms(burn_ms), .state(state),
    .done(done), .aborted(aborted)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (sep_pulse === 1'b1) sep_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      $display("check %s: got %0d expected %0d ok", tag, obs, exp);
    end else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
    int n = 0;
    while (state !== s && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(state), 32'(s));
  endtask

  task automatic write_cfg(input logic [1:0] idx, input int b, input int md, input int mp, input int dr);
    cfg_we = 1'b1; cfg_idx = idx;
    cfg_burn_ms = b; cfg_mdot = md; cfg_mprop = mp; cfg_mdry = dr;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  initial begin
    int n;
    bit stable;
    reset_n = 1'b0; cfg_we = 1'b0; cfg_idx = '0;
    cfg_burn_ms = '0; cfg_mdot = '0; cfg_mprop = '0; cfg_mdry = '0;
    launch = 1'b0; abort = 1'b0; calc_ack = 1'b0;
    @(negedge clk); @(negedge clk);
    check("rst_state", 32'(state), 0);
    check("rst_mass", mass, 0);
    check("rst_flags", {27'd0, calc_req, thrust_en, sep_pulse, done, aborted}, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Nominal configuration; the idx 3 write must be discarded.
    write_cfg(2'd0, 5, 100, 500, 200);
    write_cfg(2'd1, 3, 50, 150, 100);
    write_cfg(2'd2, 2, 10, 20, 30);
    write_cfg(2'd3, 9, 1, 7777, 8888);

    abort = 1'b1;
    @(negedge clk);
    check("idle_abort_ignored", 32'(state), 0);
    abort = 1'b0;

    launch = 1'b1;
    @(negedge clk);
    launch = 1'b0;
    check("prep_enter", 32'(state), 1);
    check("prep_mass0", mass, 0);
    @(negedge clk); check("prep_mass1", mass, 700);
    @(negedge clk); check("prep_mass2", mass, 950);
    @(negedge clk);
    check("burn_enter", 32'(state), 2);
    check("prep_total", mass, 1000);

    for (int i = 0; i < 20; i++) begin
      check($sformatf("s0_thrust_%0d", i), 32'(thrust_en), 1);
      check($sformatf("s0_burnms_%0d", i), burn_ms, 32'(i / 4));
      check($sformatf("s0_mass_%0d", i), mass, 32'(1000 - 100 * (i / 4)));
      @(negedge clk);
    end
    check("s0_thrust_off", 32'(thrust_en), 0);
    check("s0_calc_state", 32'(state), 3);
    check("s0_calc_req", 32'(calc_req), 1);
    check("s0_burnms_final", burn_ms, 5);
    check("s0_burnout_mass", mass, 500);

    stable = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (calc_req !== 1'b1 || mass !== 32'd500 || state !== 3'd3 || burn_ms !== 32'd5) stable = 1'b0;
      @(negedge clk);
    end
    check("calc_hold", 32'(stable), 1);
    calc_ack = 1'b1;
    @(negedge clk);
    calc_ack = 1'b0;
    check("s0_sep_state", 32'(state), 4);
    check("s0_sep_pulse", 32'(sep_pulse), 1);
    check("s0_req_drop", 32'(calc_req), 0);
    @(negedge clk);
    check("s0_post_sep_mass", mass, 300);
    check("s0_sep_single", 32'(sep_pulse), 0);
    n = 0;
    while (state === 3'd5 && n < 20) begin
      n++;
      @(negedge clk);
    end
    check("coast_cycles", n, 8);
    check("s1_burn_state", 32'(state), 2);
    check("s1_stage_idx", 32'(stage_idx), 1);
    check("s1_burnms_zero", burn_ms, 0);

    wait_state(3'd3, 40, "s1_reach_calc");
    check("s1_burnout_mass", mass, 150);
    calc_ack = 1'b1;
    @(negedge clk);
    calc_ack = 1'b0;
    @(negedge clk);
    check("s1_post_sep_mass", mass, 50);
    wait_state(3'd2, 20, "s2_reach_burn");
    check("s2_stage_idx", 32'(stage_idx), 2);
    wait_state(3'd3, 40, "s2_reach_calc");
    check("s2_burnout_mass", mass, 30);
    calc_ack = 1'b1;
    @(negedge clk);
    calc_ack = 1'b0;
    check("done_state", 32'(state), 6);
    check("done_flag", 32'(done), 1);
    check("done_mass", mass, 30);
    check("sep_count", sep_cnt, 2);
    abort = 1'b1;
    @(negedge clk);
    check("done_abort_ignored", 32'(state), 6);
    abort = 1'b0;

    launch = 1'b1;
    @(negedge clk);
    launch = 1'b0;
    check("done_to_idle", 32'(state), 0);
    check("done_cleared", 32'(done), 0);

    // Saturating burn; config write coincides with launch.
    cfg_we = 1'b1; cfg_idx = 2'd0;
    cfg_burn_ms = 5; cfg_mdot = 300; cfg_mprop = 500; cfg_mdry = 200;
    launch = 1'b1;
    @(negedge clk);
    cfg_we = 1'b0; launch = 1'b0;
    wait_state(3'd2, 10, "sat_reach_burn");
    for (int i = 0; i < 20; i++) begin
      check($sformatf("sat_mass_%0d", i), mass, (i < 4) ? 32'd1000 : (i < 8) ? 32'd700 : 32'd500);
      @(negedge clk);
    end
    check("sat_calc_state", 32'(state), 3);
    check("sat_burnout_mass", mass, 500);
    calc_ack = 1'b1;
    @(negedge clk);
    calc_ack = 1'b0;
    wait_state(3'd2, 20, "abort_reach_s1");
    n = 0;
    while (burn_ms !== 32'd1 && n < 10) begin
      n++;
      @(negedge clk);
    end
    check("abort_at_burnms1", burn_ms, 1);
    abort = 1'b1;
    @(negedge clk);
    check("abort_state", 32'(state), 7);
    check("abort_thrust", 32'(thrust_en), 0);
    check("abort_flag", 32'(aborted), 1);
    check("abort_req", 32'(calc_req), 0);
    launch = 1'b1;
    @(negedge clk);
    check("abort_launch_blocked", 32'(state), 7);
    launch = 1'b0; abort = 1'b0;
    @(negedge clk);
    check("abort_sticky", 32'(aborted), 1);
    launch = 1'b1;
    @(negedge clk);
    launch = 1'b0;
    check("abort_to_idle", 32'(state), 0);
    check("abort_cleared", 32'(aborted), 0);

    // Asynchronous reset in the middle of a coast.
    calc_ack = 1'b1;
    launch = 1'b1;
    @(negedge clk);
    launch = 1'b0;
    wait_state(3'd5, 100, "rst_reach_coast");
    check("coast_mass_before_rst", mass, 300);
    #2 reset_n = 1'b0;
    #1;
    check("arst_state", 32'(state), 0);
    check("arst_mass", mass, 0);
    check("arst_burnms", burn_ms, 0);
    check("arst_flags", {27'd0, calc_req, thrust_en, sep_pulse, done, aborted}, 0);
    @(negedge clk);
    reset_n = 1'b1; calc_ack = 1'b0;
    launch = 1'b1;
    @(negedge clk);
    launch = 1'b0;
    wait_state(3'd2, 10, "arst_relaunch_burn");
    check("arst_cfg_cleared_mass", mass, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
